// File: rtl/spi_cs_transaction_ctrl_pkg.sv
// Shared SPI chip-select definitions: FSM state encodings, default timing constants, timer width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_cs_transaction_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CS_SETUP    = 3'd1,
      ST_TRANSFER    = 3'd2,
      ST_CS_HOLD     = 3'd3,
      ST_CS_INACTIVE = 3'd4
   } cs_state_t;

   localparam int DEF_MAX_BYTES_PER_CS = 4;
   localparam int DEF_CS_SETUP_CLKS    = 2;
   localparam int DEF_CS_HOLD_CLKS     = 2;
   localparam int DEF_CS_INACTIVE_CLKS = 4;

   // Every CS wait fits in 1..255 cycles.
   localparam int TMR_W = 8;

   function automatic logic [TMR_W-1:0] tmr_load_val(input int clks);
      return TMR_W'(clks);
   endfunction

endpackage

// File: rtl/spi_cs_transaction_ctrl_timer.sv
// Loadable down-counter shared by the CS setup, hold and inactive waits.
// Latency: o_done is high in the last of i_load_val cycles after the load edge.
// Backpressure: none; a new load overrides any wait in progress.
//
// Ports: i_clk, i_rst (async active-high), i_load / i_load_val (start a wait), o_done (wait over).
module spi_cs_timer
   import spi_cs_transaction_ctrl_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (i_load) begin
         cnt <= i_load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Done in the final cycle of the wait, so the owner can act on the
   // following edge and the wait lasts exactly i_load_val cycles.
   assign o_done = (cnt == W'(1));

endmodule

// File: rtl/spi_cs_transaction_ctrl.sv
// Frames a burst of bytes under one SPI chip select and sequences an external byte master.
// Latency: accepted byte -> o_M_TX_DV 1 cycle (first byte waits CS_SETUP_CLKS); i_M_RX_DV -> o_RX_DV 1 cycle.
// Backpressure: o_TX_Ready (registered) is low while the byte master is busy or a byte is in flight; i_TX_DV without it is dropped.
//
// Ports: i_clk, i_rst (async active-high); user side i_TX_Count/i_TX_Byte/i_TX_DV/o_TX_Ready,
// o_RX_DV/o_RX_Byte/o_RX_Count; byte-master side o_M_TX_Byte/o_M_TX_DV, i_M_TX_Ready,
// i_M_RX_DV/i_M_RX_Byte; o_SPI_CS_n to the slave.
module spi_cs_transaction_ctrl
   import spi_cs_transaction_ctrl_pkg::*;
#(
   parameter int MAX_BYTES_PER_CS = DEF_MAX_BYTES_PER_CS,
   parameter int CS_SETUP_CLKS    = DEF_CS_SETUP_CLKS,
   parameter int CS_HOLD_CLKS     = DEF_CS_HOLD_CLKS,
   parameter int CS_INACTIVE_CLKS = DEF_CS_INACTIVE_CLKS,
   localparam int CNT_W           = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [CNT_W-1:0] i_TX_Count,
   input  logic [7:0]       i_TX_Byte,
   input  logic             i_TX_DV,
   output logic             o_TX_Ready,
   output logic             o_RX_DV,
   output logic [7:0]       o_RX_Byte,
   output logic [CNT_W-1:0] o_RX_Count,
   output logic [7:0]       o_M_TX_Byte,
   output logic             o_M_TX_DV,
   input  logic             i_M_TX_Ready,
   input  logic             i_M_RX_DV,
   input  logic [7:0]       i_M_RX_Byte,
   output logic             o_SPI_CS_n
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES_PER_CS);

   cs_state_t        state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] rx_inc;
   logic [7:0]       m_tx_byte_q, m_tx_byte_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             m_tx_dv_q, m_tx_dv_d;
   logic             rx_dv_q, rx_dv_d;
   logic             tx_ready_q, tx_ready_d;
   logic             cs_n_q, cs_n_d;
   logic             accept;
   logic             tmr_load, tmr_done;
   logic [TMR_W-1:0] tmr_val;

   assign accept = i_TX_DV && tx_ready_q;
   assign rx_inc = rx_cnt_q + 1'b1;

   spi_cs_timer #(.W(TMR_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_done     (tmr_done)
   );

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      sent_cnt_d  = sent_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      m_tx_byte_d = m_tx_byte_q;
      rx_byte_d   = rx_byte_q;
      m_tx_dv_d   = 1'b0;
      rx_dv_d     = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               m_tx_byte_d = i_TX_Byte;
               if (i_TX_Count == '0) begin
                  frame_cnt_d = CNT_W'(1);
               end else if (i_TX_Count > MAX_CNT) begin
                  frame_cnt_d = MAX_CNT;
               end else begin
                  frame_cnt_d = i_TX_Count;
               end
               sent_cnt_d = '0;
               rx_cnt_d   = '0;
               tmr_load   = 1'b1;
               tmr_val    = tmr_load_val(CS_SETUP_CLKS);
               state_d    = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            // The first byte was captured in IDLE; launch it once setup expires.
            if (tmr_done) begin
               m_tx_dv_d  = 1'b1;
               sent_cnt_d = CNT_W'(1);
               state_d    = ST_TRANSFER;
            end
         end
         ST_TRANSFER: begin
            if (accept) begin
               m_tx_byte_d = i_TX_Byte;
               m_tx_dv_d   = 1'b1;
               sent_cnt_d  = sent_cnt_q + 1'b1;
            end
            if (i_M_RX_DV) begin
               rx_dv_d   = 1'b1;
               rx_byte_d = i_M_RX_Byte;
               rx_cnt_d  = rx_inc;
               if (rx_inc == frame_cnt_q) begin
                  tmr_load = 1'b1;
                  tmr_val  = tmr_load_val(CS_HOLD_CLKS);
                  state_d  = ST_CS_HOLD;
               end
            end
         end
         ST_CS_HOLD: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = tmr_load_val(CS_INACTIVE_CLKS);
               state_d  = ST_CS_INACTIVE;
            end
         end
         ST_CS_INACTIVE: begin
            if (tmr_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // CS and ready are decoded from the next state so both register cleanly
      // and change on the same edge as the state they describe.
      cs_n_d = !((state_d == ST_CS_SETUP) || (state_d == ST_TRANSFER) ||
                 (state_d == ST_CS_HOLD));
      // In TRANSFER a new byte is offered only once the master is idle, every
      // issued byte has come back, and the frame still has room.
      tx_ready_d = (state_d == ST_IDLE) ||
                   ((state_d == ST_TRANSFER) && i_M_TX_Ready && !accept &&
                    (rx_cnt_d == sent_cnt_d) && (sent_cnt_d < frame_cnt_d));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         sent_cnt_q  <= '0;
         rx_cnt_q    <= '0;
         m_tx_byte_q <= '0;
         rx_byte_q   <= '0;
         m_tx_dv_q   <= 1'b0;
         rx_dv_q     <= 1'b0;
         tx_ready_q  <= 1'b0;
         cs_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         sent_cnt_q  <= sent_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         m_tx_byte_q <= m_tx_byte_d;
         rx_byte_q   <= rx_byte_d;
         m_tx_dv_q   <= m_tx_dv_d;
         rx_dv_q     <= rx_dv_d;
         tx_ready_q  <= tx_ready_d;
         cs_n_q      <= cs_n_d;
      end
   end

   assign o_TX_Ready  = tx_ready_q;
   assign o_RX_DV     = rx_dv_q;
   assign o_RX_Byte   = rx_byte_q;
   assign o_RX_Count  = rx_cnt_q;
   assign o_M_TX_Byte = m_tx_byte_q;
   assign o_M_TX_DV   = m_tx_dv_q;
   assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_cs_transaction_ctrl.sv
// Self-checking bench for spi_cs_transaction_ctrl with a behavioural byte-master/slave model.
// Latency: slave answers each byte 3 cycles after o_M_TX_DV with (byte ^ 8'h99).
// Backpressure: the slave holds i_M_TX_Ready low while a byte is in flight.
module tb_spi_cs_transaction_ctrl;

   localparam int CNT_W = $clog2(4 + 1);

   logic             i_clk;
   logic             i_rst = 1'b1;
   logic [CNT_W-1:0] i_TX_Count;
   logic [7:0]       i_TX_Byte;
   logic             i_TX_DV;
   logic             o_TX_Ready;
   logic             o_RX_DV;
   logic [7:0]       o_RX_Byte;
   logic [CNT_W-1:0] o_RX_Count;
   logic [7:0]       o_M_TX_Byte;
   logic             o_M_TX_DV;
   logic             i_M_TX_Ready;
   logic             i_M_RX_DV;
   logic [7:0]       i_M_RX_Byte;
   logic             o_SPI_CS_n;

   spi_cs_transaction_ctrl dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_TX_Count   (i_TX_Count),
      .i_TX_Byte    (i_TX_Byte),
      .i_TX_DV      (i_TX_DV),
      .o_TX_Ready   (o_TX_Ready),
      .o_RX_DV      (o_RX_DV),
      .o_RX_Byte    (o_RX_Byte),
      .o_RX_Count   (o_RX_Count),
      .o_M_TX_Byte  (o_M_TX_Byte),
      .o_M_TX_DV    (o_M_TX_DV),
      .i_M_TX_Ready (i_M_TX_Ready),
      .i_M_RX_DV    (i_M_RX_DV),
      .i_M_RX_Byte  (i_M_RX_Byte),
      .o_SPI_CS_n   (o_SPI_CS_n)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboards
   typedef struct { logic [7:0] b; int idx; } rx_exp_t;
   typedef struct { logic [7:0] b; bit chk_t; int t; } mtx_exp_t;
   rx_exp_t  rx_q[$];
   mtx_exp_t mtx_q[$];
   int       fr_q[$];

   // Stimulus table
   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic [7:0]       b[4];
      int               exp_n;
   } vec_t;
   vec_t vt[6];

   task automatic setv(input int i, input logic [CNT_W-1:0] c, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                       input int n);
      vt[i].cnt = c;
      vt[i].b[0] = b0; vt[i].b[1] = b1; vt[i].b[2] = b2; vt[i].b[3] = b3;
      vt[i].exp_n = n;
   endtask

   // Byte master + slave model
   initial begin
      int         lat;
      bit         busy;
      logic [7:0] sb;
      i_M_TX_Ready = 1'b1; i_M_RX_DV = 1'b0; i_M_RX_Byte = 8'h00;
      busy = 0; lat = 0; sb = 8'h00;
      forever begin
         @(negedge i_clk);
         i_M_RX_DV = 1'b0;
         if (busy) begin
            lat--;
            if (lat == 0) begin
               busy = 0;
               i_M_RX_DV = 1'b1;
               i_M_RX_Byte = sb ^ 8'h99;
               i_M_TX_Ready = 1'b1;
            end
         end else if (o_M_TX_DV && !i_rst) begin
            sb = o_M_TX_Byte;
            busy = 1;
            lat = 3;
            i_M_TX_Ready = 1'b0;
         end
      end
   end

   // Output monitor
   int t_fall = 0, t_last_rx = 0, pulses = 0, high_len = 0;
   bit prev_cs = 1'b1, first_mtx = 1'b0, win_valid = 1'b0, rdy_bad = 1'b0;

   always @(negedge i_clk) begin
      rx_exp_t  re;
      mtx_exp_t me;
      if (i_rst) begin
         win_valid = 1'b0;
         first_mtx = 1'b0;
         pulses    = 0;
         prev_cs   = o_SPI_CS_n;
      end else begin
         if (o_RX_DV) begin
            t_last_rx = cyc;
            if (rx_q.size() == 0) begin
               chk("rx_unexpected", 32'(o_RX_Byte), 32'hFFFF_FFFF);
            end else begin
               re = rx_q.pop_front();
               chk("rx_byte", 32'(o_RX_Byte), 32'(re.b));
               chk("rx_count", 32'(o_RX_Count), 32'(re.idx));
            end
         end
         if (o_M_TX_DV) begin
            pulses++;
            if (first_mtx) begin
               chk("cs_setup_clks", 32'(cyc - t_fall), 32'd2);
               first_mtx = 1'b0;
            end
            if (mtx_q.size() == 0) begin
               chk("mtx_unexpected", 32'(o_M_TX_Byte), 32'hFFFF_FFFF);
            end else begin
               me = mtx_q.pop_front();
               chk("mtx_byte", 32'(o_M_TX_Byte), 32'(me.b));
               if (me.chk_t) chk("mtx_latency", 32'(cyc), 32'(me.t));
            end
         end
         if (prev_cs && !o_SPI_CS_n) begin
            if (win_valid) chk("cs_high_min", 32'(high_len >= 4), 32'd1);
            win_valid = 1'b0;
            t_fall    = cyc;
            pulses    = 0;
            first_mtx = 1'b1;
         end
         if (!prev_cs && o_SPI_CS_n) begin
            chk("cs_hold_clks", 32'(cyc - t_last_rx), 32'd2);
            if (fr_q.size() == 0) chk("frame_unexpected", 32'(pulses), 32'hFFFF_FFFF);
            else chk("frame_pulses", 32'(pulses), 32'(fr_q.pop_front()));
            win_valid = 1'b1;
            high_len  = 0;
            rdy_bad   = 1'b0;
         end
         if (o_SPI_CS_n && win_valid && high_len < 4) begin
            if (o_TX_Ready) rdy_bad = 1'b1;
            high_len++;
            if (high_len == 4) chk("inactive_ready_low", 32'(rdy_bad), 32'd0);
         end else if (o_SPI_CS_n && win_valid) begin
            high_len++;
         end
         prev_cs = o_SPI_CS_n;
      end
   end

   // Drive one byte once o_TX_Ready allows, recording what the DUT owes us.
   task automatic send_byte(input logic [CNT_W-1:0] cnt, input logic [7:0] b, input int idx,
                            input bit first, input int exp_n, input bit push_rx);
      int n = 0;
      mtx_exp_t me;
      rx_exp_t  re;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_TX_Ready && n < 200);
      if (!o_TX_Ready) begin
         chk("tx_ready_timeout", 32'(o_TX_Ready), 32'd1);
      end else begin
         i_TX_DV = 1'b1; i_TX_Count = cnt; i_TX_Byte = b;
         me.b = b; me.chk_t = !first; me.t = cyc + 1;
         mtx_q.push_back(me);
         if (push_rx) begin
            re.b = b ^ 8'h99; re.idx = idx;
            rx_q.push_back(re);
         end
         if (first && exp_n > 0) fr_q.push_back(exp_n);
         @(negedge i_clk);
         i_TX_DV = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rx_q.size() != 0 || mtx_q.size() != 0 || fr_q.size() != 0 || !o_SPI_CS_n) && n < 400) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain_in_time", 32'(n < 400), 32'd1);
      repeat (6) @(negedge i_clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      i_TX_DV = 1'b0; i_TX_Count = '0; i_TX_Byte = 8'h00;

      setv(0, 3'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1);
      setv(1, 3'd3, 8'h01, 8'h02, 8'h03, 8'h00, 3);
      setv(2, 3'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 1);
      setv(3, 3'd7, 8'h10, 8'h20, 8'h30, 8'h40, 4);
      setv(4, 3'd4, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4);
      setv(5, 3'd2, 8'hC3, 8'h81, 8'h00, 8'h00, 2);

      // Reset values
      repeat (2) @(negedge i_clk);
      chk("rst_cs_n", 32'(o_SPI_CS_n), 32'd1);
      chk("rst_tx_ready", 32'(o_TX_Ready), 32'd0);
      chk("rst_rx_dv", 32'(o_RX_DV), 32'd0);
      chk("rst_m_tx_dv", 32'(o_M_TX_DV), 32'd0);
      chk("rst_rx_byte", 32'(o_RX_Byte), 32'd0);
      chk("rst_m_tx_byte", 32'(o_M_TX_Byte), 32'd0);
      chk("rst_rx_count", 32'(o_RX_Count), 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("ready_after_rst", 32'(o_TX_Ready), 32'd1);

      // Table-driven frames, each requested as soon as the previous one allows
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < vt[v].exp_n; k++) begin
            send_byte(vt[v].cnt, vt[v].b[k], k + 1, k == 0, vt[v].exp_n, 1'b1);
         end
      end
      wait_idle();

      // Dropped strobe while o_TX_Ready is low (during CS setup)
      send_byte(3'd2, 8'h77, 1, 1'b1, 2, 1'b1);
      @(negedge i_clk);
      chk("drop_ready_low", 32'(o_TX_Ready), 32'd0);
      i_TX_DV = 1'b1; i_TX_Byte = 8'hEE; i_TX_Count = 3'd4;
      @(negedge i_clk);
      i_TX_DV = 1'b0;
      send_byte(3'd2, 8'h66, 2, 1'b0, 2, 1'b1);
      wait_idle();

      // Reset during the second byte of a three-byte frame
      send_byte(3'd3, 8'h91, 1, 1'b1, 0, 1'b1);
      send_byte(3'd3, 8'h92, 2, 1'b0, 0, 1'b0);
      #2 i_rst = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(o_SPI_CS_n), 32'd1);
      chk("midrst_m_tx_dv", 32'(o_M_TX_DV), 32'd0);
      chk("midrst_tx_ready", 32'(o_TX_Ready), 32'd0);
      chk("midrst_rx_count", 32'(o_RX_Count), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("ready_after_midrst", 32'(o_TX_Ready), 32'd1);
      send_byte(3'd3, 8'h11, 1, 1'b1, 3, 1'b1);
      send_byte(3'd3, 8'h22, 2, 1'b0, 3, 1'b1);
      send_byte(3'd3, 8'h33, 3, 1'b0, 3, 1'b1);
      wait_idle();

      chk("rx_q_empty", 32'(rx_q.size()), 32'd0);
      chk("mtx_q_empty", 32'(mtx_q.size()), 32'd0);
      chk("frame_q_empty", 32'(fr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
